// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and arbitration helper for the unified memory arbiter
package unified_mem_arbiter_pkg;

    // FSM encodings
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    // Requester identifiers
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } arb_port_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    // Select the winning port. A lone request always wins; on a tie the data
    // port wins in fixed-priority mode, otherwise the port not granted last.
    function automatic arb_port_t pick_winner(
        input logic      if_req,
        input logic      d_req,
        input logic      rr_mode,
        input arb_port_t last_grant
    );
        arb_port_t w;
        if (if_req && d_req) begin
            if (rr_mode) begin
                w = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
            end else begin
                w = PORT_D;
            end
        end else if (d_req) begin
            w = PORT_D;
        end else begin
            w = PORT_IF;
        end
        return w;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_timeout.sv
// rtl/unified_mem_arbiter_timeout.sv - cycle counter that flags an expired memory wait
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   clear    synchronous clear to zero (has priority over enable)
//   enable   count up by one this cycle
//   expired  count has reached TIMEOUT
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between fetch and load/store ports
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request in; if_gnt/if_rvalid/if_rdata out
//   d_req/d_we/d_be/d_addr/d_wdata load/store request in; d_gnt/d_rvalid/d_rdata out
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata   memory access out
//   mem_rdata/mem_ready            memory response in
//   busy                           arbiter not idle
//   err                            one-cycle pulse when an access is abandoned
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    arb_state_t        state_q, state_d;
    arb_port_t         port_q;
    arb_port_t         last_grant_q;
    arb_port_t         winner;
    logic              req_we_q;
    logic [3:0]        req_be_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              grant;
    logic              in_busy;
    logic              expired;
    logic              mem_en_c;
    logic              err_c;

    // Byte-offset and out-of-range address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign winner  = pick_winner(if_req, d_req, (RR_MODE != 0), last_grant_q);
    // Grant is combinational from the requests; gating with reset keeps the
    // gnt outputs low while reset is held.
    assign grant   = reset && (state_q == ARB_IDLE) && (if_req || d_req);
    assign in_busy = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);

    // Counts cycles spent in BUSY_x; cleared everywhere else so every access
    // starts from zero.
    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_busy),
        .enable  (in_busy && !expired),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        mem_en_c = 1'b0;
        err_c    = 1'b0;
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    if (winner == PORT_D) begin
                        d_gnt   = 1'b1;
                        state_d = ARB_BUSY_D;
                    end else begin
                        if_gnt  = 1'b1;
                        state_d = ARB_BUSY_I;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (expired) begin
                    // Abandon the access: strobe low, flag it, no response.
                    err_c   = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    mem_en_c = 1'b1;
                    if (mem_ready) begin
                        state_d = ARB_RESP;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            port_q       <= PORT_IF;
            last_grant_q <= PORT_IF;
            req_we_q     <= 1'b0;
            req_be_q     <= 4'h0;
            req_addr_q   <= '0;
            req_wdata_q  <= 32'h0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                port_q       <= winner;
                last_grant_q <= winner;
                if (winner == PORT_D) begin
                    req_we_q    <= d_we;
                    req_be_q    <= d_be;
                    req_addr_q  <= d_addr[ADDR_W+1:2];
                    req_wdata_q <= d_wdata;
                end else begin
                    req_we_q    <= 1'b0;
                    req_be_q    <= BE_FULL;
                    req_addr_q  <= if_addr[ADDR_W+1:2];
                    req_wdata_q <= 32'h0;
                end
            end
            // Response data is captured per port so each rdata output holds
            // its own last value between rvalid pulses.
            if (mem_en_c && mem_ready) begin
                if (port_q == PORT_D) begin
                    d_rdata_q <= req_we_q ? 32'h0 : mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = mem_en_c;
    assign mem_we    = req_we_q;
    assign mem_be    = req_be_q;
    assign mem_addr  = req_addr_q;
    assign mem_wdata = req_wdata_q;
    assign if_rvalid = (state_q == ARB_RESP) && (port_q == PORT_IF);
    assign d_rvalid  = (state_q == ARB_RESP) && (port_q == PORT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != ARB_IDLE);
    assign err       = err_c;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ready, busy, err;
    logic [3:0]  mem_be;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    // Second instance in round-robin mode with an always-ready memory
    logic        r_if_req, r_d_req, r_if_gnt, r_d_gnt;
    logic        r_unused_if_rvalid, r_unused_d_rvalid, r_unused_we, r_unused_busy, r_unused_err;
    logic [31:0] r_unused_if_rdata, r_unused_d_rdata, r_unused_wdata;
    logic [3:0]  r_unused_be;
    logic        r_mem_en;
    logic [5:0]  r_mem_addr;

    unified_mem_arbiter #(.ADDR_W(6), .RR_MODE(0), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    unified_mem_arbiter #(.ADDR_W(6), .RR_MODE(1), .TIMEOUT(15)) dut_rr (
        .clk(clk), .reset(reset),
        .if_req(r_if_req), .if_addr(32'h0000_0020), .if_gnt(r_if_gnt), .if_rvalid(r_unused_if_rvalid),
        .if_rdata(r_unused_if_rdata),
        .d_req(r_d_req), .d_we(1'b0), .d_be(4'hF), .d_addr(32'h0000_0040), .d_wdata(32'h0),
        .d_gnt(r_d_gnt), .d_rvalid(r_unused_d_rvalid), .d_rdata(r_unused_d_rdata),
        .mem_en(r_mem_en), .mem_we(r_unused_we), .mem_be(r_unused_be), .mem_addr(r_mem_addr),
        .mem_wdata(r_unused_wdata), .mem_rdata({26'h0, r_mem_addr}), .mem_ready(r_mem_en),
        .busy(r_unused_busy), .err(r_unused_err)
    );

    // Memory model for the main instance
    logic [31:0] mem [64];
    int          en_cnt = 0;
    int          ready_delay = 0;
    logic        hang = 1'b0;

    assign mem_ready = mem_en && !hang && (en_cnt == ready_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
            mem[4] <= 32'h0050_0093;
            mem[9] <= 32'h1122_3344;
        end else if (mem_en && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_ready) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end

    // Scoreboard
    typedef struct packed { logic port; logic [31:0] data; } rsp_t;
    typedef struct packed { logic we; logic [3:0] be; logic [5:0] addr; logic [31:0] wdata; } acc_t;
    rsp_t rsp_q[$];
    acc_t acc_q[$];
    logic rr_exp_q[$];
    int   rr_grants = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_rsp(input logic p, input logic [31:0] d);
        rsp_q.push_back({p, d});
    endtask

    task automatic push_acc(input logic we, input logic [3:0] be, input logic [5:0] a, input logic [31:0] wd);
        acc_q.push_back({we, be, a, wd});
    endtask

    initial begin
        rsp_t e;
        acc_t a;
        logic g;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (if_rvalid || d_rvalid) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rvalid_port", {30'h0, if_rvalid, d_rvalid}, e.port ? 32'h1 : 32'h2);
                        chk("rdata", e.port ? d_rdata : if_rdata, e.data);
                    end
                end
                if (if_gnt || if_rvalid) chk("if_gnt_rvalid_excl", {31'h0, if_gnt & if_rvalid}, 32'h0);
                if (d_gnt || d_rvalid)   chk("d_gnt_rvalid_excl", {31'h0, d_gnt & d_rvalid}, 32'h0);
                if (mem_en && mem_ready) begin
                    if (acc_q.size() == 0) begin
                        chk("unexpected_mem_access", {31'h0, mem_en}, 32'h0);
                    end else begin
                        a = acc_q.pop_front();
                        chk("mem_we", {31'h0, mem_we}, {31'h0, a.we});
                        chk("mem_be", {28'h0, mem_be}, {28'h0, a.be});
                        chk("mem_addr", {26'h0, mem_addr}, {26'h0, a.addr});
                        chk("mem_wdata", mem_wdata, a.wdata);
                    end
                end
                if (r_if_gnt || r_d_gnt) begin
                    rr_grants++;
                    if (rr_exp_q.size() == 0) begin
                        chk("rr_unexpected_grant", {30'h0, r_if_gnt, r_d_gnt}, 32'h0);
                    end else begin
                        g = rr_exp_q.pop_front();
                        chk("rr_grant_order", {30'h0, r_if_gnt, r_d_gnt}, g ? 32'h1 : 32'h2);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int dg, dr, ig, en_cycles;
        logic seen;
        reset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        r_if_req = 0; r_d_req = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {25'h0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy, err}, 32'h0);
        chk("rst_mem", {mem_we, mem_be, mem_addr, 21'h0}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: lone fetch, minimum latency
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h10;
        push_rsp(1'b0, 32'h0050_0093);
        push_acc(1'b0, 4'hF, 6'd4, 32'h0);
        @(negedge clk);
        chk("t1_if_gnt_c0", {31'h0, if_gnt}, 32'h1);
        chk("t1_mem_en_c0", {31'h0, mem_en}, 32'h0);
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        chk("t1_mem_en_c1", {31'h0, mem_en}, 32'h1);
        chk("t1_if_rvalid_c1", {31'h0, if_rvalid}, 32'h0);
        @(negedge clk);
        chk("t1_if_rvalid_c2", {31'h0, if_rvalid}, 32'h1);
        chk("t1_mem_en_c2", {31'h0, mem_en}, 32'h0);
        @(negedge clk);
        chk("t1_busy_c3", {31'h0, busy}, 32'h0);

        // 2: store; inputs scrambled after grant must not matter
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h24; d_wdata = 32'hDEAD_BEEF;
        push_rsp(1'b1, 32'h0);
        push_acc(1'b1, 4'b0011, 6'd9, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_d_gnt", {31'h0, d_gnt}, 32'h1);
        @(posedge clk); #1;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 32'h3C; d_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_d_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("t2_if_rdata_hold", if_rdata, 32'h0050_0093);
        @(negedge clk);
        chk("t2_mem_word9", mem[9], 32'h1122_BEEF);

        // 3: simultaneous requests, fixed priority
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h14; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h30;
        push_rsp(1'b1, 32'hA500_000C);
        push_rsp(1'b0, 32'hA500_0005);
        push_acc(1'b0, 4'hF, 6'd12, 32'h0);
        push_acc(1'b0, 4'hF, 6'd5, 32'h0);
        dg = -1; dr = -1; ig = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_gnt && dg < 0) dg = c;
            if (d_rvalid && dr < 0) dr = c;
            if (if_gnt && ig < 0) ig = c;
            @(posedge clk); #1;
            if (dg >= 0) d_req = 0;
            if (ig >= 0) if_req = 0;
        end
        chk("t3_d_gnt_cycle", dg, 0);
        chk("t3_d_rvalid_cycle", dr, 2);
        chk("t3_if_gnt_cycle", ig, 3);

        // 5: timeout abort
        hang = 1'b1;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h08;
        @(negedge clk);
        chk("t5_d_gnt", {31'h0, d_gnt}, 32'h1);
        @(posedge clk); #1 d_req = 0;
        en_cycles = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                chk("t5_mem_en_at_err", {31'h0, mem_en}, 32'h0);
            end else if (mem_en) begin
                en_cycles++;
            end
        end
        chk("t5_err_seen", {31'h0, seen}, 32'h1);
        chk("t5_mem_en_cycles", en_cycles, 15);
        @(negedge clk);
        chk("t5_busy_after", {31'h0, busy}, 32'h0);
        chk("t5_err_once", {31'h0, err}, 32'h0);

        // 6: asynchronous reset during BUSY_D
        @(posedge clk); #1;
        d_req = 1; d_addr = 32'h04;
        @(negedge clk);
        chk("t6_d_gnt", {31'h0, d_gnt}, 32'h1);
        @(posedge clk); #1 d_req = 0;
        repeat (3) @(negedge clk);
        chk("t6_busy_before", {31'h0, busy}, 32'h1);
        #2 reset = 1'b0; if_req = 1; if_addr = 32'h10;
        #1;
        chk("t6_rst_ctrl", {25'h0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy, err}, 32'h0);
        chk("t6_rst_if_rdata", if_rdata, 32'h0);
        chk("t6_rst_mem_addr", {26'h0, mem_addr}, 32'h0);
        hang = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        push_rsp(1'b0, 32'h0050_0093);
        push_acc(1'b0, 4'hF, 6'd4, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (if_gnt) seen = 1'b1;
        end
        chk("t6_if_gnt_after_reset", {31'h0, seen}, 32'h1);
        @(posedge clk); #1 if_req = 0;
        for (int c = 0; c < 10 && rsp_q.size() != 0; c++) @(negedge clk);
        chk("t6_rsp_drained", rsp_q.size(), 0);
        chk("t6_acc_drained", acc_q.size(), 0);

        // 4: round-robin under continuous contention
        rr_exp_q.push_back(1'b1);
        rr_exp_q.push_back(1'b0);
        rr_exp_q.push_back(1'b1);
        rr_exp_q.push_back(1'b0);
        @(posedge clk); #1;
        r_if_req = 1; r_d_req = 1;
        for (int c = 0; c < 30 && rr_grants < 4; c++) begin
            @(posedge clk); #1;
        end
        r_if_req = 0; r_d_req = 0;
        repeat (6) @(negedge clk);
        chk("t4_rr_grant_count", rr_grants, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
